// File: rtl/unary_pkg.sv
// unary_pkg: shared definitions for the unary stream generator.
//   state_t    - FSM states (IDLE waits for a frame, STREAM emits beats)
//   beat_count - beats per frame, 2**BWIDTH / UWIDTH
//   cnt_width  - width of a counter that spans 0..beats-1 (at least 1 bit)
package unary_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    function automatic int beat_count(input int bwidth, input int uwidth);
        return (2 ** bwidth) / uwidth;
    endfunction

    function automatic int cnt_width(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/unary_stream_gen_if.sv
// unary_stream_gen_if: binary-in / unary-out stream bundle.
//   bin_in       [NCH][BWIDTH] per-lane binary value N_c
//   mode                       0 = ones first, 1 = ones last
//   bin_in_valid/bin_in_ready  frame handshake
//   u_out        [NCH][UWIDTH] current beat per lane
//   u_out_valid/u_out_ready    beat handshake
//   u_out_last                 final beat of a frame
//   done                       one-cycle pulse after the final beat handshake
// master = frame source / beat sink, slave = the generator.
interface unary_stream_gen_if #(
    parameter int UWIDTH = 2,
    parameter int BWIDTH = 4,
    parameter int NCH    = 1
);
    logic [NCH-1:0][BWIDTH-1:0] bin_in;
    logic                       mode;
    logic                       bin_in_valid;
    logic                       bin_in_ready;
    logic [NCH-1:0][UWIDTH-1:0] u_out;
    logic                       u_out_valid;
    logic                       u_out_ready;
    logic                       u_out_last;
    logic                       done;

    modport master (
        output bin_in, mode, bin_in_valid, u_out_ready,
        input  bin_in_ready, u_out, u_out_valid, u_out_last, done
    );

    modport slave (
        input  bin_in, mode, bin_in_valid, u_out_ready,
        output bin_in_ready, u_out, u_out_valid, u_out_last, done
    );
endinterface

// File: rtl/unary_stream_gen_lane.sv
// unary_lane: per-lane threshold comparator.
//   i_n    lane value N
//   i_mode 0 = bit set when index < N, 1 = bit set when index >= L-N
//   i_k    shared beat counter
//   i_en   high while streaming; output forced to zero otherwise
//   o_bits UWIDTH unary bits for beat i_k, bit j = frame position k*UWIDTH+j
// All index math is BWIDTH+1 bits so L-N with N=0 does not wrap.
module unary_lane
    import unary_pkg::*;
#(
    parameter int UWIDTH = 2,
    parameter int BWIDTH = 4,
    parameter int KW     = 3
) (
    input  logic [BWIDTH-1:0] i_n,
    input  logic              i_mode,
    input  logic [KW-1:0]     i_k,
    input  logic              i_en,
    output logic [UWIDTH-1:0] o_bits
);
    localparam int IW = BWIDTH + 1;
    localparam logic [IW-1:0] LEN = IW'(2 ** BWIDTH);

    logic [IW-1:0] w_n;
    logic [IW-1:0] w_lo;
    logic [IW-1:0] w_base;

    assign w_n    = {1'b0, i_n};
    assign w_lo   = LEN - w_n;
    assign w_base = IW'(i_k) * IW'(UWIDTH);

    always_comb begin
        o_bits = '0;
        for (int j = 0; j < UWIDTH; j++) begin
            if (i_mode)
                o_bits[j] = i_en && ((w_base + IW'(j)) >= w_lo);
            else
                o_bits[j] = i_en && ((w_base + IW'(j)) < w_n);
        end
    end
endmodule

// File: rtl/unary_stream_gen.sv
// unary_stream_gen: converts per-lane binary values into unary frames of
// L = 2**BWIDTH bits, emitted UWIDTH bits per lane per beat over
// B = L/UWIDTH beats.
//   clk, reset  clock and asynchronous active-high reset
//   s           slave side of unary_stream_gen_if (frame in, beats out)
// One FSM and beat counter are shared by all lanes; each lane is a
// unary_lane comparator on the captured value.
module unary_stream_gen
    import unary_pkg::*;
#(
    parameter int UWIDTH = 2,
    parameter int BWIDTH = 4,
    parameter int NCH    = 1
) (
    input  logic               clk,
    input  logic               reset,
    unary_stream_gen_if.slave  s
);
    localparam int B  = beat_count(BWIDTH, UWIDTH);
    localparam int KW = cnt_width(B);
    localparam logic [KW-1:0] K_LAST = KW'(B - 1);

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [KW-1:0]              r_k;
    logic [KW-1:0]              w_k_nxt;
    logic [NCH-1:0][BWIDTH-1:0] r_n;
    logic                       r_mode;
    logic                       r_done;

    logic                       w_stream;
    logic                       w_last;
    logic                       w_hs;
    logic                       w_ready;
    logic                       w_accept;
    logic [NCH-1:0][UWIDTH-1:0] w_u;

    assign w_stream = (r_state == STREAM);
    assign w_last   = w_stream && (r_k == K_LAST);
    assign w_hs     = w_stream && s.u_out_ready;
    // Ready also during the final handshake so back-to-back frames
    // stream without an idle beat between them.
    assign w_ready  = !w_stream || (w_last && s.u_out_ready);
    assign w_accept = s.bin_in_valid && w_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = STREAM;
                    w_k_nxt     = '0;
                end
            end
            STREAM: begin
                if (w_hs) begin
                    if (w_last) begin
                        w_k_nxt     = '0;
                        w_state_nxt = w_accept ? STREAM : IDLE;
                    end else begin
                        w_k_nxt = r_k + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_k_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_n     <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_k     <= w_k_nxt;
            r_done  <= w_hs && w_last;
            if (w_accept) begin
                r_n    <= s.bin_in;
                r_mode <= s.mode;
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_lane
        unary_lane #(
            .UWIDTH (UWIDTH),
            .BWIDTH (BWIDTH),
            .KW     (KW)
        ) u_lane (
            .i_n    (r_n[c]),
            .i_mode (r_mode),
            .i_k    (r_k),
            .i_en   (w_stream),
            .o_bits (w_u[c])
        );
    end

    assign s.bin_in_ready = w_ready;
    assign s.u_out        = w_u;
    assign s.u_out_valid  = w_stream;
    assign s.u_out_last   = w_last;
    assign s.done         = r_done;
endmodule
